// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, flag bit positions and datapath width.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADDU = 3'd0;
  localparam logic [2:0] OP_ADDS = 3'd1;
  localparam logic [2:0] OP_SUBU = 3'd2;
  localparam logic [2:0] OP_SUBS = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 0;

  function automatic logic carry_op(input logic [2:0] op);
    return (op == OP_ADDU) || (op == OP_SUBU);
  endfunction

  function automatic logic ovf_op(input logic [2:0] op);
    return (op == OP_ADDS) || (op == OP_SUBS);
  endfunction

endpackage

// File: rtl/alu_result_queue_sat_counter.sv
// Saturating event counter; clear takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr)
      value_d = '0;
    else if (inc && (value_q != '1))
      value_d = value_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      value_q <= '0;
    else
      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/alu_result_queue.sv
// FWFT result queue behind the ALU with carry/overflow/zero event counters.
module alu_result_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_carryout,
  input  logic                     in_overflow,
  input  logic                     in_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_opcode,
  output logic [DATA_W-1:0]        out_result,
  output logic [2:0]               out_flags,
  input  logic                     flush,
  input  logic                     clear_stats,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         carry_cnt,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         zero_cnt
);

  import alu_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + 6;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [EW-1:0] head;
  logic [2:0]    in_flags;
  logic          full, empty, push, pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = wr_ptr_q - rd_ptr_q;

  always_comb begin
    in_flags        = '0;
    in_flags[FLG_C] = in_carryout;
    in_flags[FLG_V] = in_overflow;
    in_flags[FLG_Z] = in_zero;
  end

  // Flush resets both pointers and masks any pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push)
      mem_d[wr_ptr_q[AW-1:0]] = {in_opcode, in_result, in_flags};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head       = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign out_opcode = head[EW-1 -: 3];
  assign out_result = head[3 +: DATA_W];
  assign out_flags  = head[2:0];

  sat_counter #(.CNT_W(CNT_W)) u_carry (
    .clk   (clk),
    .reset (reset),
    .inc   (push && in_carryout && carry_op(in_opcode)),
    .clr   (clear_stats),
    .value (carry_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ovf (
    .clk   (clk),
    .reset (reset),
    .inc   (push && in_overflow && ovf_op(in_opcode)),
    .clr   (clear_stats),
    .value (ovf_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_zero (
    .clk   (clk),
    .reset (reset),
    .inc   (push && in_zero),
    .clr   (clear_stats),
    .value (zero_cnt)
  );

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue; a CNT_W=4 copy checks saturation.
module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready, flush, clear_stats;
  logic [2:0]  in_opcode;
  logic [15:0] in_result;
  logic        in_carryout, in_overflow, in_zero;

  logic        in_ready, out_valid;
  logic [2:0]  out_opcode, out_flags;
  logic [15:0] out_result;
  logic [2:0]  count;
  logic [15:0] carry_cnt, ovf_cnt, zero_cnt;

  logic        s_in_ready, s_out_valid;
  logic [2:0]  s_out_opcode, s_out_flags;
  logic [15:0] s_out_result;
  logic [2:0]  s_count;
  logic [3:0]  s_carry_cnt, s_ovf_cnt, s_zero_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_queue #(.DEPTH(4), .DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result),
    .in_carryout(in_carryout), .in_overflow(in_overflow),
    .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_result(out_result),
    .out_flags(out_flags),
    .flush(flush), .clear_stats(clear_stats),
    .count(count),
    .carry_cnt(carry_cnt), .ovf_cnt(ovf_cnt), .zero_cnt(zero_cnt)
  );

  alu_result_queue #(.DEPTH(4), .DATA_W(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_opcode(in_opcode), .in_result(in_result),
    .in_carryout(in_carryout), .in_overflow(in_overflow),
    .in_zero(in_zero),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_opcode(s_out_opcode), .out_result(s_out_result),
    .out_flags(s_out_flags),
    .flush(flush), .clear_stats(clear_stats),
    .count(s_count),
    .carry_cnt(s_carry_cnt), .ovf_cnt(s_ovf_cnt), .zero_cnt(s_zero_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    clear_stats = 1'b0;
    in_opcode   = 3'd0;
    in_result   = 16'h0;
    in_carryout = 1'b0;
    in_overflow = 1'b0;
    in_zero     = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_hs: rdy=%b vld=%b cnt=%0d want 1 0 0",
               in_ready, out_valid, count);
    end
    checks++;
    if ({out_opcode, out_result, out_flags} !== 22'h0 ||
        carry_cnt !== 0 || ovf_cnt !== 0 || zero_cnt !== 0) begin
      errors++;
      $display("FAIL reset_data: op=%0d res=%h fl=%b c=%0d v=%0d z=%0d want 0",
               out_opcode, out_result, out_flags,
               carry_cnt, ovf_cnt, zero_cnt);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    in_valid  = 1'b1;
    in_opcode = 3'd0;
    in_result = 16'h0010;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h0010 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_push: vld=%b res=%h cnt=%0d want 1 0010 1",
               out_valid, out_result, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: vld=%b cnt=%0d want 0 0", out_valid, count);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid  = 1'b1;
      in_opcode = 3'd5;
      in_result = 16'(i);
      #0;
      checks++;
      if (in_ready !== (i <= 4)) begin
        errors++;
        $display("FAIL full_ready%0d: rdy=%b want %b", i, in_ready, (i <= 4));
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_count: cnt=%0d rdy=%b want 4 0", count, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 16'(k)) begin
        errors++;
        $display("FAIL drain%0d: vld=%b res=%0d want 1 %0d",
                 k, out_valid, out_result, k);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: cnt=%0d vld=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    in_valid  = 1'b1;
    in_opcode = 3'd1;
    in_result = 16'd100;
    tick();
    in_result = 16'd101;
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_result = 16'(102 + c);
      if (out_result !== 16'(100 + c)) begin
        bad++;
        $display("FAIL b2b_order%0d: res=%0d want %0d",
                 c, out_result, 100 + c);
      end
      tick();
      if (count !== 3'd2) begin
        bad++;
        $display("FAIL b2b_count%0d: cnt=%0d want 2", c, count);
      end
    end
    checks++;
    if (bad != 0) errors++;
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 16'(120 + k)) begin
        errors++;
        $display("FAIL b2b_tail%0d: vld=%b res=%0d want 1 %0d",
                 k, out_valid, out_result, 120 + k);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_empty: cnt=%0d want 0", count);
    end
  endtask

  task automatic push_flags(input logic [2:0] op, input logic c,
                            input logic v, input logic z);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_carryout = c;
    in_overflow = v;
    in_zero     = z;
    tick();
    in_valid    = 1'b0;
    in_carryout = 1'b0;
    in_overflow = 1'b0;
    in_zero     = 1'b0;
  endtask

  task automatic test_counters();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    out_ready   = 1'b1;
    push_flags(3'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (carry_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cnt_subu_carry: got %0d want 1", carry_cnt);
    end
    push_flags(3'd4, 1'b1, 1'b0, 1'b0);
    checks++;
    if (carry_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cnt_and_carry: got %0d want 1", carry_cnt);
    end
    push_flags(3'd3, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ovf_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cnt_subs_ovf: got %0d want 1", ovf_cnt);
    end
    push_flags(3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ovf_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cnt_addu_ovf: got %0d want 1", ovf_cnt);
    end
    push_flags(3'd6, 1'b0, 1'b0, 1'b1);
    checks++;
    if (zero_cnt !== 16'd1 || carry_cnt !== 16'd1 || ovf_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cnt_xor_zero: z=%0d c=%0d v=%0d want 1 1 1",
               zero_cnt, carry_cnt, ovf_cnt);
    end
    checks++;
    if (out_flags !== 3'b001 || out_opcode !== 3'd6) begin
      errors++;
      $display("FAIL cnt_head_flags: fl=%b op=%0d want 001 6",
               out_flags, out_opcode);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    out_ready   = 1'b1;
    for (int i = 0; i < 17; i++)
      push_flags(3'd5, 1'b0, 1'b0, 1'b1);
    checks++;
    if (s_zero_cnt !== 4'd15 || zero_cnt !== 16'd17) begin
      errors++;
      $display("FAIL sat_zero: w4=%0d w16=%0d want 15 17",
               s_zero_cnt, zero_cnt);
    end
    clear_stats = 1'b1;
    push_flags(3'd5, 1'b0, 1'b0, 1'b1);
    clear_stats = 1'b0;
    checks++;
    if (s_zero_cnt !== 4'd0 || zero_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clear_wins: w4=%0d w16=%0d want 0 0",
               s_zero_cnt, zero_cnt);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_opcode = 3'd4;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_result = 16'(16'hA1 + i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre: cnt=%0d want 3", count);
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_result = 16'h00EE;
    in_zero   = 1'b1;
    out_ready = 1'b1;
    #0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: rdy=%b want 0", in_ready);
    end
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || zero_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flush_post: cnt=%0d vld=%b z=%0d want 0 0 0",
               count, out_valid, zero_cnt);
    end
    in_valid  = 1'b1;
    in_result = 16'h0055;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || out_result !== 16'h0055) begin
      errors++;
      $display("FAIL flush_next: cnt=%0d res=%h want 1 0055",
               count, out_result);
    end
  endtask

  task automatic test_reset_mid();
    in_valid    = 1'b1;
    in_opcode   = 3'd2;
    in_result   = 16'h1234;
    in_carryout = 1'b1;
    tick();
    tick();
    in_valid    = 1'b0;
    in_carryout = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 ||
        out_result !== 16'h0 || out_opcode !== 3'd0 || out_flags !== 3'd0 ||
        carry_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b cnt=%0d res=%h c=%0d want 1 0 0 0 0",
               in_ready, out_valid, count, out_result, carry_cnt);
    end
    tick();
    reset = 1'b1;
    tick();
    in_valid  = 1'b1;
    in_opcode = 3'd7;
    in_result = 16'h0077;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || out_result !== 16'h0077 || out_opcode !== 3'd7) begin
      errors++;
      $display("FAIL reset_after: cnt=%0d res=%h op=%0d want 1 0077 7",
               count, out_result, out_opcode);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_counters();
    test_saturation();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Downstream stage of `myalu`. It captures each ALU result together with its opcode and flags into a small first-word-fall-through FIFO, using a valid/ready handshake on both sides. It also keeps saturating event counters for carry, overflow and zero results, and hands results to the writeback/consumer logic at whatever rate that logic accepts them.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DATA_W`, 16: result width; matches the ALU datapath.
- `CNT_W`, 16: width of each statistics counter.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; assertion clears all state immediately.
- `in_valid` in 1: producer presents an entry.
- `in_ready` out 1: queue will accept the entry this cycle.
- `in_opcode` in 3: ALU opcode that produced the result.
- `in_result` in DATA_W: ALU result.
- `in_carryout`, `in_overflow`, `in_zero` in 1 each: ALU flags.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer takes the head entry.
- `out_opcode` out 3, `out_result` out DATA_W, `out_flags` out 3: head entry; `out_flags` is {carry, overflow, zero}.
- `flush` in 1: synchronous; discards all entries.
- `clear_stats` in 1: synchronous; zeroes the counters.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `carry_cnt`, `ovf_cnt`, `zero_cnt` out CNT_W: event counters.

## Operation
- Push: `in_valid & in_ready`. Pop: `out_valid & out_ready`.
- `in_ready = (count != DEPTH) & !flush`.
  - No bypass: when full, an entry cannot be pushed in the same cycle as a pop.
- `out_valid = (count != 0)`. Outputs are driven from the storage entry at the read pointer.
  - When `out_valid`=0, out data must not be relied on; a zero/don't-care value is acceptable.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Full: pointer MSBs differ and the remaining bits are equal.
  - Empty: pointers are equal.
- Simultaneous push and pop (non-full, non-empty): occupancy is unchanged and both pointers advance.
- Push into an empty queue plus pop in the same cycle is impossible, because `out_valid`=0.
- `flush`: the next cycle has count=0 and the pointers are reset. A concurrent push is refused (`in_ready`=0) and a concurrent pop is ignored.
- Counters update only on an accepted push:
  - `carry_cnt` +1 if `in_carryout` and opcode ∈ {0,2} (unsigned add/sub).
  - `ovf_cnt` +1 if `in_overflow` and opcode ∈ {1,3} (signed add/sub).
  - `zero_cnt` +1 if `in_zero`, for any opcode.
  - Each counter saturates at 2^CNT_W−1 and never wraps.
- `clear_stats` wins over a same-cycle increment: the counter becomes 0, not 1. `clear_stats` does not affect the FIFO, and `flush` does not affect the counters.
- Opcode map: 0 add-u, 1 add-s, 2 sub-u, 3 sub-s, 4 AND, 5 OR, 6 XOR, 7 shift-right-by-1.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `count`=0.
  - `out_opcode`/`out_result`/`out_flags`=0.
  - All counters 0 and both pointers 0.
- Latency: an entry pushed at edge N is visible with `out_valid`=1 after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained, except that a full queue needs one pop cycle before it accepts again.
- `count` and counters are registered and reflect edge N in cycle N+1.
- Reset mid-operation: all entries are lost, outputs return to reset values asynchronously, and the first push after deassertion behaves as into an empty queue.
- `in_ready` depends combinationally only on internal state and `flush`, never on `out_ready`.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode localparams `OP_ADDU`..`OP_SHR` (0..7).
  - Flag bit indices `FLG_C=2`, `FLG_V=1`, `FLG_Z=0`.
  - `DATA_W` default.
- One natural sub-module: `sat_counter` (CNT_W, inc, clr, value), instantiated three times.
- Storage is a flop array of DEPTH × (3+DATA_W+3) bits.

## Test plan
- Reset then push opcode 0, result 0x0010, flags 000 at cycle 2. Expect `out_valid`=1 in cycle 3 with `out_result`=0x0010, `count`=1; pop it, then `count`=0 and `out_valid`=0.
- With `out_ready`=0, push 5 entries (results 1..5). Expect `in_ready`=0 after the 4th, the 5th not accepted, `count`=4; then drain and expect the order 1,2,3,4.
- Hold `count`=2 and push+pop every cycle for 20 cycles. Expect `count` to stay at 2, output order to match input order, and the pointers to wrap without loss.
- Counter filtering:
  - Push opcode 2 with carry=1 → `carry_cnt`=1.
  - Push opcode 4 with carry=1 → unchanged.
  - Push opcode 3 with ovf=1 → `ovf_cnt`=1.
  - Push opcode 0 with ovf=1 → unchanged.
  - Push opcode 6 with zero=1 → `zero_cnt`=1.
- CNT_W=4: 17 zero-flag pushes give `zero_cnt`=15. `clear_stats` plus a zero push in the same cycle gives 0.
- With 3 entries held, assert `flush` while `in_valid`=1 and `out_ready`=1. Next cycle expect `count`=0, `out_valid`=0, and the pushed entry absent. Assert `reset` low mid-stream and expect all outputs at reset values immediately.
